// File: rtl/parameter_dispatcher_pkg.sv
// ----------------------------------------------------------------------------
// parameter_dispatcher_pkg
//   Shared constants for the CGRA parameter dispatcher: FSM state encodings
//   and the default buffer-head settle time.
// ----------------------------------------------------------------------------
package parameter_dispatcher_pkg;

    // FSM encodings kept as plain 2-bit constants so they can be matched
    // against older netlists and waveform dumps that use the same values.
    localparam logic [1:0] PD_IDLE   = 2'd0;
    localparam logic [1:0] PD_SETTLE = 2'd1;
    localparam logic [1:0] PD_ISSUE  = 2'd2;

    localparam int PD_SETTLE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/parameter_dispatcher_decoder.sv
// ----------------------------------------------------------------------------
// pe_onehot_decoder
//   Turns a destination PE id into a one-hot RF write-enable vector and flags
//   whether the id names an existing PE.
//   Ports:
//     pe_id_i   in  PE_ID_WIDTH  destination PE id
//     onehot_o  out PE_COUNT     one-hot select, all zero for an illegal id
//     valid_o   out 1            id < PE_COUNT
// ----------------------------------------------------------------------------
module pe_onehot_decoder #(
    parameter int PE_ID_WIDTH = 2,
    parameter int PE_COUNT    = 4
) (
    input  logic [PE_ID_WIDTH-1:0] pe_id_i,
    output logic [PE_COUNT-1:0]    onehot_o,
    output logic                   valid_o
);

    always_comb begin
        valid_o = (32'(pe_id_i) < PE_COUNT);
        for (int i = 0; i < PE_COUNT; i++) begin
            onehot_o[i] = (pe_id_i == PE_ID_WIDTH'(i));
        end
    end

endmodule

// File: rtl/parameter_dispatcher.sv
// ----------------------------------------------------------------------------
// parameter_dispatcher
//   Drains the CGRA parameter buffer and writes each entry into the register
//   file of its destination PE. A buffer head must be stable for
//   SETTLE_CYCLES cycles before it is popped; the pop (ISSUE) only starts
//   while the RF write window is open, and the registered RF write follows
//   one cycle later.
//   Ports:
//     CGRA_CLK_I        in  clock
//     RST_N_I           in  asynchronous active-low reset
//     EN_I              in  global enable, low freezes all state
//     WINDOW_I          in  RF write window open
//     BUF_EMPTY_I       in  buffer empty flag
//     BUF_DATA_I        in  head entry data
//     BUF_PE_I          in  head entry destination PE
//     BUF_RF_OFFSET_I   in  head entry RF offset
//     BUF_NEXT_O        out pop pulse
//     RF_WE_O           out one-hot RF write enable
//     RF_ADDR_O         out RF write address (shared)
//     RF_DATA_O         out RF write data (shared)
//     BAD_PE_O          out popped entry had an illegal PE id
//     BUSY_O            out FSM not idle
//     DISPATCH_COUNT_O  out RF writes performed since reset (wrapping)
// ----------------------------------------------------------------------------
module parameter_dispatcher
    import parameter_dispatcher_pkg::*;
#(
    parameter int PARAMETER_WIDTH = 32,
    parameter int PE_ID_WIDTH     = 2,
    parameter int RF_WIDTH        = 6,
    parameter int PE_COUNT        = 4,
    parameter int SETTLE_CYCLES   = PD_SETTLE_CYCLES_DEFAULT,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       CGRA_CLK_I,
    input  logic                       RST_N_I,
    input  logic                       EN_I,
    input  logic                       WINDOW_I,
    input  logic                       BUF_EMPTY_I,
    input  logic [PARAMETER_WIDTH-1:0] BUF_DATA_I,
    input  logic [PE_ID_WIDTH-1:0]     BUF_PE_I,
    input  logic [RF_WIDTH-1:0]        BUF_RF_OFFSET_I,
    output logic                       BUF_NEXT_O,
    output logic [PE_COUNT-1:0]        RF_WE_O,
    output logic [RF_WIDTH-1:0]        RF_ADDR_O,
    output logic [PARAMETER_WIDTH-1:0] RF_DATA_O,
    output logic                       BAD_PE_O,
    output logic                       BUSY_O,
    output logic [COUNT_WIDTH-1:0]     DISPATCH_COUNT_O
);

    localparam int CNT_WIDTH = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]                 state_q, state_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [PE_COUNT-1:0]        we_q, we_d;
    logic                       bad_q, bad_d;
    logic [RF_WIDTH-1:0]        addr_q, addr_d;
    logic [PARAMETER_WIDTH-1:0] data_q, data_d;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;

    logic [PE_COUNT-1:0]        pe_onehot;
    logic                       pe_valid;

    pe_onehot_decoder #(
        .PE_ID_WIDTH (PE_ID_WIDTH),
        .PE_COUNT    (PE_COUNT)
    ) u_decoder (
        .pe_id_i  (BUF_PE_I),
        .onehot_o (pe_onehot),
        .valid_o  (pe_valid)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bad_d   = bad_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;

        if (EN_I) begin
            // Write/bad pulses last exactly one enabled cycle.
            we_d  = '0;
            bad_d = 1'b0;

            case (state_q)
                PD_IDLE: begin
                    if (!BUF_EMPTY_I) begin
                        state_d = PD_SETTLE;
                        cnt_d   = '0;
                    end
                end

                PD_SETTLE: begin
                    if (cnt_q != CNT_WIDTH'(SETTLE_CYCLES)) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    if (BUF_EMPTY_I) begin
                        state_d = PD_IDLE;
                        cnt_d   = '0;
                    end else if ((cnt_q >= CNT_WIDTH'(SETTLE_CYCLES - 1)) && WINDOW_I) begin
                        // A closed window simply parks here with the counter
                        // saturated; the head is held so its fields stay valid.
                        state_d = PD_ISSUE;
                    end
                end

                PD_ISSUE: begin
                    // Committed: the write happens regardless of WINDOW_I and
                    // BUF_EMPTY_I in this cycle.
                    state_d = PD_SETTLE;
                    cnt_d   = '0;
                    if (pe_valid) begin
                        we_d    = pe_onehot;
                        addr_d  = BUF_RF_OFFSET_I;
                        data_d  = BUF_DATA_I;
                        count_d = count_q + COUNT_WIDTH'(1);
                    end else begin
                        bad_d = 1'b1;
                    end
                end

                default: begin
                    state_d = PD_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= PD_IDLE;
            cnt_q   <= '0;
            we_q    <= '0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Pulses are gated by EN_I so a frozen dispatcher never pops or writes.
    assign BUF_NEXT_O       = EN_I && (state_q == PD_ISSUE);
    assign RF_WE_O          = EN_I ? we_q : '0;
    assign BAD_PE_O         = EN_I && bad_q;
    assign RF_ADDR_O        = addr_q;
    assign RF_DATA_O        = data_q;
    assign BUSY_O           = (state_q != PD_IDLE);
    assign DISPATCH_COUNT_O = count_q;

endmodule

// File: tb/tb_parameter_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_parameter_dispatcher
//   Directed bench for parameter_dispatcher with PE_COUNT=3, SETTLE_CYCLES=4.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_parameter_dispatcher;

    localparam int PW = 32;
    localparam int IW = 2;
    localparam int RW = 6;
    localparam int PC = 3;
    localparam int SC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          window;
    logic          buf_empty;
    logic [PW-1:0] buf_data;
    logic [IW-1:0] buf_pe;
    logic [RW-1:0] buf_off;
    logic          buf_next;
    logic [PC-1:0] rf_we;
    logic [RW-1:0] rf_addr;
    logic [PW-1:0] rf_data;
    logic          bad_pe;
    logic          busy;
    logic [CW-1:0] dispatch_count;

    int tests_run   = 0;
    int tests_failed = 0;
    int exp_count   = 0;

    always #5 clk = ~clk;

    parameter_dispatcher #(
        .PARAMETER_WIDTH (PW),
        .PE_ID_WIDTH     (IW),
        .RF_WIDTH        (RW),
        .PE_COUNT        (PC),
        .SETTLE_CYCLES   (SC),
        .COUNT_WIDTH     (CW)
    ) dut (
        .CGRA_CLK_I       (clk),
        .RST_N_I          (rst_n),
        .EN_I             (en),
        .WINDOW_I         (window),
        .BUF_EMPTY_I      (buf_empty),
        .BUF_DATA_I       (buf_data),
        .BUF_PE_I         (buf_pe),
        .BUF_RF_OFFSET_I  (buf_off),
        .BUF_NEXT_O       (buf_next),
        .RF_WE_O          (rf_we),
        .RF_ADDR_O        (rf_addr),
        .RF_DATA_O        (rf_data),
        .BAD_PE_O         (bad_pe),
        .BUSY_O           (busy),
        .DISPATCH_COUNT_O (dispatch_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Counts falling edges until BUF_NEXT_O is seen; -1 if the budget expires.
    task automatic wait_next(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (buf_next) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic present(input logic [IW-1:0] pe, input logic [RW-1:0] off, input logic [PW-1:0] data);
        buf_pe    = pe;
        buf_off   = off;
        buf_data  = data;
        buf_empty = 1'b0;
    endtask

    task automatic drain();
        buf_empty = 1'b1;
        buf_pe    = '0;
        buf_off   = '0;
        buf_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        logic [PC-1:0] exp_we;

        // ---- 1: reset with a non-empty buffer ----
        rst_n  = 1'b0;
        en     = 1'b1;
        window = 1'b1;
        present(2'd1, 6'd7, 32'h1234_5678);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | buf_next;
        end
        check("rst_next", 64'(seen), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_addr", 64'(rf_addr), 64'd0);
        check("rst_data", 64'(rf_data), 64'd0);
        check("rst_bad", 64'(bad_pe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(dispatch_count), 64'd0);
        drain();
        rst_n = 1'b1;
        step();
        step();

        // ---- 2: single entry ----
        present(2'd2, 6'd5, 32'hDEAD_BEEF);
        wait_next(20, n);
        check("single_next_lat", 64'(n), 64'd5);
        step();
        drain();
        exp_count++;
        check("single_we", 64'(rf_we), 64'b100);
        check("single_addr", 64'(rf_addr), 64'd5);
        check("single_data", 64'(rf_data), 64'hDEAD_BEEF);
        check("single_count", 64'(dispatch_count), 64'(exp_count));
        step();
        check("single_we_off", 64'(rf_we), 64'd0);
        check("single_addr_hold", 64'(rf_addr), 64'd5);
        step();
        step();
        check("single_idle", 64'(busy), 64'd0);

        // ---- 3: three back-to-back entries ----
        present(2'd0, 6'd1, 32'h1111_1111);
        wait_next(20, n);
        check("b2b0_gap", 64'(n), 64'd5);
        step();
        exp_count++;
        check("b2b0_we", 64'(rf_we), 64'b001);
        check("b2b0_data", 64'(rf_data), 64'h1111_1111);
        present(2'd1, 6'd63, 32'hA5A5_5A5A);
        wait_next(20, n);
        check("b2b1_gap", 64'(n + 1), 64'd5);
        step();
        exp_count++;
        check("b2b1_we", 64'(rf_we), 64'b010);
        check("b2b1_addr", 64'(rf_addr), 64'd63);
        check("b2b1_data", 64'(rf_data), 64'hA5A5_5A5A);
        present(2'd2, 6'd0, 32'h0000_0001);
        wait_next(20, n);
        check("b2b2_gap", 64'(n + 1), 64'd5);
        step();
        drain();
        exp_count++;
        check("b2b2_we", 64'(rf_we), 64'b100);
        check("b2b2_addr", 64'(rf_addr), 64'd0);
        check("b2b2_count", 64'(dispatch_count), 64'(exp_count));
        step();
        step();

        // ---- 4: closed window stall, then commit across window fall ----
        window = 1'b0;
        present(2'd1, 6'd42, 32'hCAFE_F00D);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | buf_next | (|rf_we);
        end
        check("win_closed_quiet", 64'(seen), 64'd0);
        check("win_closed_busy", 64'(busy), 64'd1);
        window = 1'b1;
        wait_next(20, n);
        check("win_open_lat", 64'(n), 64'd1);
        window = 1'b0;
        step();
        drain();
        exp_count++;
        check("win_commit_we", 64'(rf_we), 64'b010);
        check("win_commit_addr", 64'(rf_addr), 64'd42);
        check("win_commit_data", 64'(rf_data), 64'hCAFE_F00D);
        window = 1'b1;
        step();
        step();

        // ---- 5: illegal PE id ----
        present(2'd3, 6'd9, 32'hBAD0_BAD0);
        wait_next(20, n);
        check("bad_next_lat", 64'(n), 64'd5);
        check("bad_early", 64'(bad_pe), 64'd0);
        step();
        drain();
        check("bad_pulse", 64'(bad_pe), 64'd1);
        check("bad_we", 64'(rf_we), 64'd0);
        check("bad_count", 64'(dispatch_count), 64'(exp_count));
        step();
        check("bad_pulse_end", 64'(bad_pe), 64'd0);
        step();

        // ---- 6: enable freeze during SETTLE ----
        present(2'd0, 6'd17, 32'h0BAD_CAFE);
        step();
        step();
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            seen = seen | buf_next | (|rf_we) | bad_pe;
        end
        check("frz_quiet", 64'(seen), 64'd0);
        check("frz_busy", 64'(busy), 64'd1);
        check("frz_addr_hold", 64'(rf_addr), 64'd42);
        en = 1'b1;
        wait_next(20, n);
        check("frz_resume_lat", 64'(n), 64'd3);
        step();
        drain();
        exp_count++;
        exp_we = 3'b001;
        check("frz_we", 64'(rf_we), 64'(exp_we));
        check("frz_data", 64'(rf_data), 64'h0BAD_CAFE);
        check("frz_count", 64'(dispatch_count), 64'(exp_count));
        step();
        step();

        // ---- reset in the middle of ISSUE ----
        present(2'd2, 6'd3, 32'h7777_7777);
        wait_next(20, n);
        check("mid_next_lat", 64'(n), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_next_drop", 64'(buf_next), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        step();
        check("mid_we", 64'(rf_we), 64'd0);
        check("mid_count", 64'(dispatch_count), 64'd0);
        drain();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
